// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter enums for the peripheral bus arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ADDR  = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_FAULT = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ahb_periph_arbiter_adrdec.sv
// Single-region address decoder: address match plus size and permission
// qualification for one peripheral region.
module ahb_periph_arbiter_adrdec
    import ahb_pkg::*;
#(
    parameter int PA_BITS = 34
) (
    input  logic [PA_BITS-1:0] adr,
    input  logic [1:0]         size,
    input  owner_e             owner,
    input  logic               write,
    input  logic [PA_BITS-1:0] base,
    input  logic [PA_BITS-1:0] range_mask,
    input  logic               supported,
    input  logic [3:0]         size_mask,
    input  logic               exec_ok,
    input  logic               write_ok,
    output logic               hit
);

    logic adr_match;
    logic size_ok;
    logic access_ok;

    // A set range bit is an offset bit inside the region and is ignored.
    assign adr_match = &((adr ~^ base) | range_mask);
    assign size_ok   = size_mask[size];
    assign access_ok = (owner == OWNER_I) ? exec_ok : (write ? write_ok : 1'b1);
    assign hit       = adr_match & supported & size_ok & access_ok;

endmodule

// File: rtl/ahb_periph_arbiter.sv
// Round-robin arbiter between fetch (I) and load/store (D) requesters that
// issues one AHB-Lite transfer per grant, or a local access fault.
module ahb_periph_arbiter
    import ahb_pkg::*;
#(
    parameter int PA_BITS  = 34,
    parameter int XLEN     = 64,
    parameter int NREGIONS = 4
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     IReq,
    input  logic [PA_BITS-1:0]       IAdr,
    input  logic [1:0]               ISize,
    output logic                     IGnt,
    output logic                     IDone,
    output logic                     IErr,
    output logic [XLEN-1:0]          IRData,
    input  logic                     DReq,
    input  logic [PA_BITS-1:0]       DAdr,
    input  logic [1:0]               DSize,
    input  logic                     DWrite,
    input  logic [XLEN-1:0]          DWData,
    output logic                     DGnt,
    output logic                     DDone,
    output logic                     DErr,
    output logic [XLEN-1:0]          DRData,
    input  logic [NREGIONS*PA_BITS-1:0] RegionBase,
    input  logic [NREGIONS*PA_BITS-1:0] RegionRange,
    input  logic [NREGIONS-1:0]      RegionSupported,
    input  logic [NREGIONS*4-1:0]    RegionSizeMask,
    input  logic [NREGIONS-1:0]      RegionExecOK,
    input  logic [NREGIONS-1:0]      RegionWriteOK,
    output logic [NREGIONS-1:0]      HSEL,
    output logic [PA_BITS-1:0]       HADDR,
    output logic [2:0]               HSIZE,
    output logic                     HWRITE,
    output logic [1:0]               HTRANS,
    output logic [XLEN-1:0]          HWDATA,
    input  logic                     HREADY,
    input  logic [XLEN-1:0]          HRDATA,
    input  logic                     HRESP
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_gnt_q, last_gnt_d;
    logic [PA_BITS-1:0]    adr_q, adr_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [NREGIONS-1:0]   sel_q, sel_d;

    logic                  arb_open;
    logic                  grant_any;
    owner_e                winner;
    logic [PA_BITS-1:0]    cand_adr;
    logic [1:0]            cand_size;
    logic                  cand_write;
    logic [XLEN-1:0]       cand_wdata;
    logic [NREGIONS-1:0]   hit_vec;
    logic [NREGIONS-1:0]   sel_onehot;

    logic                  done;
    logic                  err;
    logic [XLEN-1:0]       rdata;

    // Grants are combinational, so they are also held off while reset is applied.
    assign arb_open = HRESETn && (state_q == ARB_IDLE);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        winner    = OWNER_I;
        if (arb_open) begin
            if (IReq && DReq) begin
                grant_any = 1'b1;
                winner    = (last_gnt_q == OWNER_I) ? OWNER_D : OWNER_I;
            end else if (IReq) begin
                grant_any = 1'b1;
                winner    = OWNER_I;
            end else if (DReq) begin
                grant_any = 1'b1;
                winner    = OWNER_D;
            end
        end
    end

    assign cand_adr   = (winner == OWNER_D) ? DAdr   : IAdr;
    assign cand_size  = (winner == OWNER_D) ? DSize  : ISize;
    assign cand_write = (winner == OWNER_D) ? DWrite : 1'b0;
    assign cand_wdata = (winner == OWNER_D) ? DWData : '0;

    // Decode runs on the fields being latched, so the region choice lands with them.
    for (genvar k = 0; k < NREGIONS; k++) begin : g_dec
        ahb_periph_arbiter_adrdec #(
            .PA_BITS(PA_BITS)
        ) u_dec (
            .adr        (cand_adr),
            .size       (cand_size),
            .owner      (winner),
            .write      (cand_write),
            .base       (RegionBase[k*PA_BITS +: PA_BITS]),
            .range_mask (RegionRange[k*PA_BITS +: PA_BITS]),
            .supported  (RegionSupported[k]),
            .size_mask  (RegionSizeMask[k*4 +: 4]),
            .exec_ok    (RegionExecOK[k]),
            .write_ok   (RegionWriteOK[k]),
            .hit        (hit_vec[k])
        );
    end

    // Isolate the lowest set bit: lowest region index wins overlapping hits.
    assign sel_onehot = hit_vec & (~hit_vec + NREGIONS'(1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        adr_d      = adr_q;
        size_d     = size_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_any) begin
                    owner_d    = winner;
                    last_gnt_d = winner;
                    adr_d      = cand_adr;
                    size_d     = cand_size;
                    write_d    = cand_write;
                    wdata_d    = cand_wdata;
                    sel_d      = sel_onehot;
                    state_d    = (|hit_vec) ? ARB_ADDR : ARB_FAULT;
                end
            end
            ARB_ADDR:  state_d = ARB_DATA;
            ARB_DATA:  if (HREADY) state_d = ARB_IDLE;
            ARB_FAULT: state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_I;
            last_gnt_q <= OWNER_I;
            adr_q      <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            sel_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            adr_q      <= adr_d;
            size_q     <= size_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
        end
    end

    assign done  = (state_q == ARB_FAULT) || ((state_q == ARB_DATA) && HREADY);
    assign err   = (state_q == ARB_FAULT) ? 1'b1 : HRESP;
    assign rdata = (state_q == ARB_DATA) ? HRDATA : '0;

    assign IGnt   = grant_any && (winner == OWNER_I);
    assign DGnt   = grant_any && (winner == OWNER_D);
    assign IDone  = done && (owner_q == OWNER_I);
    assign DDone  = done && (owner_q == OWNER_D);
    assign IErr   = IDone && err;
    assign DErr   = DDone && err;
    assign IRData = IDone ? rdata : '0;
    assign DRData = DDone ? rdata : '0;

    assign HSEL   = ((state_q == ARB_ADDR) || (state_q == ARB_DATA)) ? sel_q : '0;
    assign HADDR  = (state_q == ARB_ADDR) ? adr_q : '0;
    assign HSIZE  = (state_q == ARB_ADDR) ? {1'b0, size_q} : 3'b000;
    assign HWRITE = (state_q == ARB_ADDR) && write_q;
    assign HTRANS = (state_q == ARB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWDATA = (state_q == ARB_DATA) ? wdata_q : '0;

endmodule

// File: tb/tb_ahb_periph_arbiter.sv
// Randomized self-checking bench for ahb_periph_arbiter against a
// transaction-level reference of the arbitration and decode rules.
`timescale 1ns/1ps
module tb_ahb_periph_arbiter;
    import ahb_pkg::*;

    localparam int PA = 34;
    localparam int XL = 64;
    localparam int NR = 4;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic IReq = 1'b0, DReq = 1'b0, DWrite = 1'b0;
    logic [PA-1:0] IAdr = '0, DAdr = '0;
    logic [1:0] ISize = '0, DSize = '0;
    logic [XL-1:0] DWData = '0;
    logic IGnt, IDone, IErr, DGnt, DDone, DErr, HWRITE;
    logic [XL-1:0] IRData, DRData, HWDATA;
    logic [NR*PA-1:0] RegionBase, RegionRange;
    logic [NR*4-1:0] RegionSizeMask;
    logic [NR-1:0] sup, exec_ok, wr_ok, HSEL;
    logic [PA-1:0] HADDR;
    logic [2:0] HSIZE;
    logic [1:0] HTRANS;
    logic HREADY = 1'b0, HRESP = 1'b0;
    logic [XL-1:0] HRDATA = '0;

    logic [PA-1:0] base_arr [NR];
    logic [PA-1:0] range_arr [NR];
    logic [3:0] smask [NR];

    assign RegionBase     = {base_arr[3], base_arr[2], base_arr[1], base_arr[0]};
    assign RegionRange    = {range_arr[3], range_arr[2], range_arr[1], range_arr[0]};
    assign RegionSizeMask = {smask[3], smask[2], smask[1], smask[0]};

    always #5 HCLK = ~HCLK;

    ahb_periph_arbiter #(.PA_BITS(PA), .XLEN(XL), .NREGIONS(NR)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .IReq(IReq), .IAdr(IAdr), .ISize(ISize), .IGnt(IGnt), .IDone(IDone), .IErr(IErr), .IRData(IRData),
        .DReq(DReq), .DAdr(DAdr), .DSize(DSize), .DWrite(DWrite), .DWData(DWData),
        .DGnt(DGnt), .DDone(DDone), .DErr(DErr), .DRData(DRData),
        .RegionBase(RegionBase), .RegionRange(RegionRange), .RegionSupported(sup),
        .RegionSizeMask(RegionSizeMask), .RegionExecOK(exec_ok), .RegionWriteOK(wr_ok),
        .HSEL(HSEL), .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: who was granted last and what each requester holds.
    bit m_last_d;
    bit pend_i, pend_d, auto_i, auto_d, allow_cancel;
    logic [PA-1:0] i_adr, d_adr;
    logic [1:0] i_size, d_size;
    bit d_write;
    logic [XL-1:0] d_wdata;
    int waits_fixed = -1;
    int resp_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_region(input bit is_d, input logic [PA-1:0] a,
                                      input logic [1:0] sz, input bit wr);
        for (int k = 0; k < NR; k++) begin
            if ((a & ~range_arr[k]) != (base_arr[k] & ~range_arr[k])) continue;
            if (!sup[k] || !smask[k][sz]) continue;
            if (!is_d && !exec_ok[k]) continue;
            if (is_d && wr && !wr_ok[k]) continue;
            return k;
        end
        return -1;
    endfunction

    function automatic logic [PA-1:0] rand_adr();
        int r;
        logic [PA-1:0] a;
        r = $urandom_range(0, 4);
        if (r == 4) a = PA'({$urandom, $urandom});
        else a = base_arr[r] | (PA'({$urandom, $urandom}) & range_arr[r]);
        if ($urandom_range(0, 7) == 0) a = a ^ (PA'(1) << $urandom_range(12, PA-1));
        return a;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_IGnt"}, IGnt, 0);
        check({tag, "_IDone"}, IDone, 0);
        check({tag, "_IErr"}, IErr, 0);
        check({tag, "_IRData"}, IRData, 0);
        check({tag, "_DGnt"}, DGnt, 0);
        check({tag, "_DDone"}, DDone, 0);
        check({tag, "_DErr"}, DErr, 0);
        check({tag, "_DRData"}, DRData, 0);
        check({tag, "_HSEL"}, HSEL, 0);
        check({tag, "_HADDR"}, HADDR, 0);
        check({tag, "_HSIZE"}, HSIZE, 0);
        check({tag, "_HWRITE"}, HWRITE, 0);
        check({tag, "_HTRANS"}, HTRANS, HTRANS_IDLE);
        check({tag, "_HWDATA"}, HWDATA, 0);
    endtask

    // During a transfer: hold the loser's request, scramble the owner's inputs.
    task automatic drive_busy(input bit is_d);
        if (allow_cancel && $urandom_range(0, 5) == 0) begin
            if (is_d) pend_i = 0;
            else pend_d = 0;
        end
        IReq = pend_i | auto_i;
        DReq = pend_d | auto_d;
        if (is_d) begin
            DAdr = rand_adr(); DSize = 2'($urandom); DWrite = 1'($urandom); DWData = {$urandom, $urandom};
        end else begin
            IAdr = rand_adr(); ISize = 2'($urandom);
        end
    endtask

    task automatic run_transfer(input bit is_d, input logic [PA-1:0] adr, input logic [1:0] sz,
                                input bit wr, input logic [XL-1:0] wd);
        int k;
        int waits;
        logic [XL-1:0] rd;
        bit rsp;
        k = ref_region(is_d, adr, sz, wr);
        waits = (waits_fixed >= 0) ? waits_fixed : $urandom_range(0, 3);
        tick();
        drive_busy(is_d);
        HREADY = 1'($urandom); HRESP = 0;
        @(negedge HCLK);
        check("busy_IGnt", IGnt, 0);
        check("busy_DGnt", DGnt, 0);
        if (k < 0) begin
            check("fault_IDone", IDone, !is_d);
            check("fault_DDone", DDone, is_d);
            check("fault_Err", is_d ? DErr : IErr, 1);
            check("fault_RData", is_d ? DRData : IRData, 0);
            check("fault_HTRANS", HTRANS, HTRANS_IDLE);
            check("fault_HSEL", HSEL, 0);
            return;
        end
        check("addr_HSEL", HSEL, NR'(1) << k);
        check("addr_HADDR", HADDR, adr);
        check("addr_HSIZE", HSIZE, {1'b0, sz});
        check("addr_HWRITE", HWRITE, wr);
        check("addr_HTRANS", HTRANS, HTRANS_NONSEQ);
        check("addr_IDone", IDone, 0);
        check("addr_DDone", DDone, 0);
        for (int w = 0; w < waits; w++) begin
            tick();
            drive_busy(is_d);
            HREADY = 0; HRDATA = {$urandom, $urandom}; HRESP = 1'($urandom);
            @(negedge HCLK);
            check("wait_HSEL", HSEL, NR'(1) << k);
            check("wait_HTRANS", HTRANS, HTRANS_IDLE);
            check("wait_IDone", IDone, 0);
            check("wait_DDone", DDone, 0);
            check("wait_Gnt", {IGnt, DGnt}, 0);
            if (is_d) check("wait_HWDATA", HWDATA, wd);
        end
        tick();
        drive_busy(is_d);
        rd = {$urandom, $urandom};
        rsp = (resp_mode == 2) ? 1'($urandom) : (resp_mode == 1);
        HREADY = 1; HRDATA = rd; HRESP = rsp;
        @(negedge HCLK);
        check("data_IDone", IDone, !is_d);
        check("data_DDone", DDone, is_d);
        check("data_Err", is_d ? DErr : IErr, rsp);
        check("data_RData", is_d ? DRData : IRData, rd);
        check("data_HSEL", HSEL, NR'(1) << k);
        check("data_Gnt", {IGnt, DGnt}, 0);
        if (is_d) check("data_HWDATA", HWDATA, wd);
    endtask

    // One cycle with the bus idle: expect the round-robin grant, then run it.
    task automatic idle_cycle();
        bit granted;
        bit want_d;
        tick();
        if (auto_i) pend_i = 1;
        if (auto_d) pend_d = 1;
        HREADY = 1'($urandom); HRESP = 0;
        IReq = pend_i; IAdr = i_adr; ISize = i_size;
        DReq = pend_d; DAdr = d_adr; DSize = d_size; DWrite = d_write; DWData = d_wdata;
        @(negedge HCLK);
        granted = pend_i || pend_d;
        want_d = (pend_i && pend_d) ? !m_last_d : pend_d;
        check("arb_IGnt", IGnt, granted && !want_d);
        check("arb_DGnt", DGnt, granted && want_d);
        check("idle_Done", {IDone, DDone}, 0);
        check("idle_HTRANS", HTRANS, HTRANS_IDLE);
        if (granted) begin
            m_last_d = want_d;
            if (want_d) begin
                pend_d = 0;
                run_transfer(1'b1, d_adr, d_size, d_write, d_wdata);
            end else begin
                pend_i = 0;
                run_transfer(1'b0, i_adr, i_size, 1'b0, '0);
            end
        end
    endtask

    task automatic do_reset();
        HRESETn = 0;
        IReq = 0; DReq = 0;
        pend_i = 0; pend_d = 0; auto_i = 0; auto_d = 0;
        #1;
        check_all_zero("rst");
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1;
        m_last_d = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        base_arr[0] = 34'h0_1000_0000; range_arr[0] = 34'h0_0000_0FFF; smask[0] = 4'b1111;
        base_arr[1] = 34'h0_2000_0000; range_arr[1] = 34'h0_0000_00FF; smask[1] = 4'b1111;
        base_arr[2] = 34'h2_0000_0000; range_arr[2] = 34'h0_0000_FFFF; smask[2] = 4'b0111;
        base_arr[3] = 34'h0_1000_0000; range_arr[3] = 34'h0_000F_FFFF; smask[3] = 4'b0011;
        sup = 4'b1111; exec_ok = 4'b1001; wr_ok = 4'b0111;
        allow_cancel = 0;
        i_adr = '0; i_size = '0; d_adr = '0; d_size = '0; d_write = 0; d_wdata = '0;

        do_reset();

        // Single zero-wait read to region 1.
        waits_fixed = 0; resp_mode = 0;
        d_adr = base_arr[1] + 34'd8; d_size = 2'd3; d_write = 0; pend_d = 1;
        idle_cycle();

        // Both requesters held from reset: D, I, D, I every third cycle.
        do_reset();
        i_adr = base_arr[0] + 34'h40; i_size = 2'd2;
        d_adr = base_arr[1] + 34'h10; d_size = 2'd3; d_write = 0;
        auto_i = 1; auto_d = 1;
        for (int n = 0; n < 4; n++) idle_cycle();
        auto_i = 0; auto_d = 0; pend_i = 0; pend_d = 0;
        idle_cycle();

        // Fetch from a non-executable region faults without a bus cycle.
        i_adr = base_arr[1] + 34'h4; i_size = 2'd2; pend_i = 1;
        idle_cycle();

        // Store with three wait states.
        waits_fixed = 3;
        d_adr = base_arr[0] + 34'h100; d_size = 2'd2; d_write = 1; d_wdata = 64'hDEAD_BEEF; pend_d = 1;
        idle_cycle();

        // Error response from the subordinate, then an illegal size.
        waits_fixed = 1; resp_mode = 1;
        d_adr = base_arr[1] + 34'h20; d_size = 2'd3; d_write = 0; pend_d = 1;
        idle_cycle();
        resp_mode = 0;
        d_adr = base_arr[2] + 34'h100; d_size = 2'd3; d_write = 0; pend_d = 1;
        idle_cycle();

        // Reset while waiting in the data phase.
        tick();
        d_adr = base_arr[1] + 34'h30; d_size = 2'd3; d_write = 0;
        IReq = 0; DReq = 1; DAdr = d_adr; DSize = d_size; DWrite = 0;
        @(negedge HCLK);
        check("rstmid_DGnt", DGnt, 1);
        tick();
        DReq = 0;
        @(negedge HCLK);
        check("rstmid_HTRANS", HTRANS, HTRANS_NONSEQ);
        tick();
        HREADY = 0;
        @(negedge HCLK);
        check("rstmid_HSEL", HSEL, 4'b0010);
        #2;
        HRESETn = 0;
        #1;
        check_all_zero("rstmid");
        tick();
        HREADY = 1;
        @(negedge HCLK);
        check("rstmid_noDone", DDone, 0);
        check("rstmid_HSEL0", HSEL, 0);
        HRESETn = 1;
        m_last_d = 0;
        waits_fixed = 0;
        i_adr = base_arr[0] + 34'h8; i_size = 2'd1;
        pend_i = 1; pend_d = 1;
        idle_cycle();
        check("rstmid_I_still_pending", {31'd0, pend_i}, 1);
        idle_cycle();

        // Randomized traffic under randomized region permissions.
        waits_fixed = -1; resp_mode = 2; allow_cancel = 1;
        for (int b = 0; b < 4; b++) begin
            sup = 4'($urandom) | 4'b0001;
            exec_ok = 4'($urandom);
            wr_ok = 4'($urandom);
            for (int k = 0; k < NR; k++) smask[k] = 4'($urandom) | 4'b0001;
            for (int c = 0; c < 80; c++) begin
                if (pend_i && $urandom_range(0, 7) == 0) pend_i = 0;
                if (pend_d && $urandom_range(0, 7) == 0) pend_d = 0;
                if (!pend_i && $urandom_range(0, 2) == 0) begin
                    i_adr = rand_adr(); i_size = 2'($urandom); pend_i = 1;
                end
                if (!pend_d && $urandom_range(0, 2) == 0) begin
                    d_adr = rand_adr(); d_size = 2'($urandom); d_write = 1'($urandom);
                    d_wdata = {$urandom, $urandom}; pend_d = 1;
                end
                idle_cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
